// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA timing path: 640x480@60 defaults,
// coordinate width and the sync-window bound helpers.
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int sync_first(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_last(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Enabled wrap counter for one raster axis; wrap is a one-cycle strobe
// on the enabled edge that returns count to zero.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] wrap_at,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == wrap_at);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters, registered position/sync decode
// and a per-frame tick with a wrapping frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_active,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick,
  output logic [7:0]         frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate range");
    end
  endgenerate

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(sync_first(H_ACTIVE, H_FP));
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(sync_first(V_ACTIVE, V_FP));
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));

  logic [COORD_W-1:0] hc;
  logic [COORD_W-1:0] vc;
  logic               h_wrap;
  logic               v_en;
  logic               v_wrap_unused;
  logic               in_hs;
  logic               in_vs;
  logic               frame_evt;

  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(.W(COORD_W)) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (pix_en),
    .wrap_at (H_LAST),
    .count   (hc),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(.W(COORD_W)) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (v_en),
    .wrap_at (V_LAST),
    .count   (vc),
    .wrap    (v_wrap_unused)
  );

  assign in_hs     = (hc >= HS_FIRST) && (hc <= HS_LAST);
  assign in_vs     = (vc >= VS_FIRST) && (vc <= VS_LAST);
  assign frame_evt = pix_en && (hc == '0) && (vc == V_ACT_C);

  // Output stage: decode of the pre-increment counters, all fields on one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x            <= '0;
      y            <= '0;
      frame_active <= 1'b0;
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
    end else if (pix_en) begin
      x            <= hc;
      y            <= vc;
      frame_active <= (hc < H_ACT_C) && (vc < V_ACT_C);
      hsync        <= in_hs ? SYNC_POL : ~SYNC_POL;
      vsync        <= in_vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Tick clears on every clk so it stays one cycle wide when pix_en idles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_tick <= frame_evt;
      if (frame_evt) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
